// File: rtl/vote_deglitch_if.sv
// Signal bundle between the raw vote detector and its conditioning stage.
// Master drives the glitchy vote and clear; slave returns the clean level, strobes and count.
interface vote_deglitch_if #(
   parameter int CNT_W = 8
);
   logic             din;
   logic             clr;
   logic             dout;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] count;

   modport master (output din, output clr, input dout, input rise, input fall, input count);
   modport slave  (input din, input clr, output dout, output rise, output fall, output count);
endinterface

// File: rtl/vote_deglitch.sv
// Synchronises and debounces the vote detector output, emitting level, edge strobes and a
// saturating rise counter; the counter and clr exist only when VOTE_DEGLITCH_COUNTER_EN is defined.
module vote_deglitch #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic            clk,
   input logic            rst,
   vote_deglitch_if.slave bus
);

   localparam int QW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {LOW, QUAL_HIGH, HIGH, QUAL_LOW} state_t;

   state_t          state, next_state;
   logic [QW-1:0]   q, q_next;
   logic            s1, s2;
   logic            dout_q, dout_next;
   logic            rise_q, rise_next;
   logic            fall_q, fall_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bus.din;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= LOW;
         q      <= '0;
         dout_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         state  <= next_state;
         q      <= q_next;
         dout_q <= dout_next;
         rise_q <= rise_next;
         fall_q <= fall_next;
      end
   end

   // q counts how many consecutive s2 samples have disagreed with the committed level
   always_comb begin
      next_state = state;
      q_next     = q;
      dout_next  = dout_q;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state)
         LOW: begin
            if (s2) begin
               if (STABLE_CYCLES == 1) begin
                  next_state = HIGH;
                  dout_next  = 1'b1;
                  rise_next  = 1'b1;
                  q_next     = '0;
               end else begin
                  next_state = QUAL_HIGH;
                  q_next     = QW'(1);
               end
            end else begin
               q_next = '0;
            end
         end
         QUAL_HIGH: begin
            if (!s2) begin
               next_state = LOW;
               q_next     = '0;
            end else if (q == QW'(STABLE_CYCLES - 1)) begin
               next_state = HIGH;
               dout_next  = 1'b1;
               rise_next  = 1'b1;
               q_next     = '0;
            end else begin
               q_next = q + 1'b1;
            end
         end
         HIGH: begin
            if (!s2) begin
               if (STABLE_CYCLES == 1) begin
                  next_state = LOW;
                  dout_next  = 1'b0;
                  fall_next  = 1'b1;
                  q_next     = '0;
               end else begin
                  next_state = QUAL_LOW;
                  q_next     = QW'(1);
               end
            end else begin
               q_next = '0;
            end
         end
         QUAL_LOW: begin
            if (s2) begin
               next_state = HIGH;
               q_next     = '0;
            end else if (q == QW'(STABLE_CYCLES - 1)) begin
               next_state = LOW;
               dout_next  = 1'b0;
               fall_next  = 1'b1;
               q_next     = '0;
            end else begin
               q_next = q + 1'b1;
            end
         end
         default: begin
            next_state = LOW;
            q_next     = '0;
         end
      endcase
   end

   assign bus.dout = dout_q;
   assign bus.rise = rise_q;
   assign bus.fall = fall_q;

`ifdef VOTE_DEGLITCH_COUNTER_EN
   logic [CNT_W-1:0] count_q;

   // clr has priority over a coincident rise; the count sticks at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (bus.clr) begin
         count_q <= '0;
      end else if (rise_next && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign bus.count = count_q;
`else
   logic unused_clr;
   assign unused_clr = bus.clr;
   assign bus.count  = '0;
`endif

endmodule

// File: tb/tb_vote_deglitch.sv
// Table-driven bench for vote_deglitch (STABLE_CYCLES=4, CNT_W=2), with hand-written
// async-reset sequences; expected count collapses to 0 when VOTE_DEGLITCH_COUNTER_EN is undefined.
module tb_vote_deglitch;

   localparam int STABLE_CYCLES = 4;
   localparam int CNT_W         = 2;
`ifdef VOTE_DEGLITCH_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic din;
      logic clr;
      logic dout;
      logic rise;
      logic fall;
      int   count;
   } vec_t;

   logic clk;
   logic rst;
   int   check_count;
   int   pass_count;
   vec_t vecs[$];

   vote_deglitch_if #(.CNT_W(CNT_W)) bus ();

   vote_deglitch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic din, input logic clr);
      bus.din = din;
      bus.clr = clr;
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
   endtask

   task automatic checkOutput(input string name, input logic e_dout, input logic e_rise,
                              input logic e_fall, input int e_count);
      int exp_cnt;
      exp_cnt = CNT_EN ? e_count : 0;
      checkBit({name, "_dout"}, bus.dout, e_dout);
      checkBit({name, "_rise"}, bus.rise, e_rise);
      checkBit({name, "_fall"}, bus.fall, e_fall);
      check_count++;
      if (int'(bus.count) == exp_cnt) pass_count++;
      else $display("[TB] FAIL %s_count: got %0d, expected %0d", name, bus.count, exp_cnt);
   endtask

   function automatic void addRow(logic din, logic clr, logic dout, logic rise, logic fall, int count);
      vec_t v;
      v.din = din; v.clr = clr; v.dout = dout; v.rise = rise; v.fall = fall; v.count = count;
      vecs.push_back(v);
   endfunction

   // A qualified change: old level for 5 sampled edges, commit with strobe on the 6th, then hold
   function automatic void addTrans(logic newd, int cnt_before, int cnt_after, logic clr_at_commit);
      for (int i = 0; i < 5; i++) addRow(newd, 1'b0, ~newd, 1'b0, 1'b0, cnt_before);
      addRow(newd, clr_at_commit, newd, newd, ~newd, cnt_after);
      addRow(newd, 1'b0, newd, 1'b0, 1'b0, cnt_after);
   endfunction

   // A 3-cycle excursion away from the committed level, which must be ignored
   function automatic void addGlitch(logic d, logic dout, int cnt);
      for (int i = 0; i < 3; i++) addRow(d, 1'b0, dout, 1'b0, 1'b0, cnt);
      for (int i = 0; i < 5; i++) addRow(~d, 1'b0, dout, 1'b0, 1'b0, cnt);
   endfunction

   task automatic runRows(input string tag);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].din, vecs[i].clr);
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s_row%0d", tag, i), vecs[i].dout, vecs[i].rise,
                     vecs[i].fall, vecs[i].count);
      end
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0);
      #1 rst = 1'b1;
      #1 checkOutput("reset_initial", 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      checkOutput("reset_held", 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      addGlitch(1'b1, 1'b0, 0);
      addTrans(1'b1, 0, 1, 1'b0);
      addGlitch(1'b0, 1'b1, 1);
      addTrans(1'b0, 1, 1, 1'b0);
      addTrans(1'b1, 1, 2, 1'b0);
      addTrans(1'b0, 2, 2, 1'b0);
      addTrans(1'b1, 2, 3, 1'b0);
      addTrans(1'b0, 3, 3, 1'b0);
      addTrans(1'b1, 3, 3, 1'b0);
      addTrans(1'b0, 3, 3, 1'b0);
      addTrans(1'b1, 3, 3, 1'b0);
      addTrans(1'b0, 3, 3, 1'b0);
      addTrans(1'b1, 3, 0, 1'b1);
      addTrans(1'b0, 0, 0, 1'b0);
      addTrans(1'b1, 0, 1, 1'b0);
      runRows("main");

      // Mid-cycle reset while HIGH with din held high: outputs clear before any edge
      #3 rst = 1'b1;
      #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      checkOutput("async_reset_held", 1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;

      // din is still high, so a full qualification from scratch is needed
      vecs.delete();
      addTrans(1'b1, 0, 1, 1'b0);
      runRows("post_reset");

      // Reset in the middle of a fall qualification, then requalify the high level
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("midqual_reset", 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      vecs.delete();
      for (int i = 0; i < 8; i++) addRow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      addTrans(1'b1, 0, 1, 1'b0);
      runRows("midqual");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/vote_deglitch.md
# vote_deglitch

Downstream conditioning stage for the 4-input "two-or-three-active" vote detector. The detector's output is purely combinational and glitches while its inputs change, so this block synchronises it, accepts a level only after it has been stable for a programmable number of cycles, and emits the clean level, one-cycle edge strobes and a saturating count of qualified assertions for display or further logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronised samples required to accept a new level; legal range ≥ 1.
- `CNT_W`, default 8: width of the event counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `din`  in  1  raw, possibly glitchy, vote output (asynchronous to `clk`).
- `clr`  in  1  synchronous clear of `count`.
- `dout`  out  1  filtered level.
- `rise`  out  1  one-cycle pulse on an accepted 0→1 change.
- `fall`  out  1  one-cycle pulse on an accepted 1→0 change.
- `count`  out  CNT_W  number of accepted rises, saturating.

## Operation
- Two-flop synchroniser `s1` → `s2` on `din`; both reset to 0.
- FSM with 4 states: LOW, QUAL_HIGH, HIGH, QUAL_LOW; reset state is LOW.
- Qualification counter `q` of width clog2(STABLE_CYCLES+1) counts consecutive samples of `s2` that differ from `dout`.
- LOW: `s2`=0 → stay, `q`=0. `s2`=1 → if STABLE_CYCLES=1, go to HIGH and commit; else go to QUAL_HIGH with `q`=1.
- QUAL_HIGH: `s2`=0 → LOW, `q`=0 (glitch rejected, no strobe). `s2`=1 and `q`+1 = STABLE_CYCLES → HIGH and commit; otherwise `q`++.
- HIGH and QUAL_LOW mirror LOW and QUAL_HIGH with polarities swapped.
- Commit to HIGH: `dout`←1, `rise`←1 for exactly one cycle, and the event counter increments. Commit to LOW: `dout`←0, `fall`←1 for exactly one cycle.
- Counter: increments by 1 per accepted rise and holds at 2^CNT_W−1. `clr` forces it to 0. If `clr` and a rise coincide, `clr` wins and the result is 0.
- Reset at any time, including mid-qualification, forces `s1`, `s2`, `q`, the state, `dout`, `rise`, `fall` and `count` to 0 and the state to LOW, regardless of `clk`. After release, a full qualification is required from scratch.

## Timing
- Reset values: `dout`=0, `rise`=0, `fall`=0, `count`=0.
- All outputs are registered; there is no combinational path from `din` or `clr` to any output.
- Latency: `din` changes and is first captured at edge E. Then `s2` changes at E+1, and `dout`, `rise`/`fall` and `count` update at edge E+1+STABLE_CYCLES (edge E+5 for the default).
- A `din` pulse or gap shorter than STABLE_CYCLES cycles, as seen at `s2`, produces no change on any output.
- `rise` and `fall` are never asserted simultaneously and never for 2 consecutive cycles.
- `clr` takes effect at the next edge; `count` reads 0 in the following cycle.

## Configuration
- Macro: `VOTE_DEGLITCH_COUNTER_EN`.
- Defined: the event counter and `clr` behave as described above.
- Undefined: no counter flops are built, `count` is tied to 0, and `clr` is ignored. The port list is unchanged; `dout`, `rise` and `fall` behave identically in both builds.

## Test plan
- Reset: assert `rst` mid-cycle with `din`=1 → all outputs read 0 immediately, before the next `clk` edge; state is LOW after release.
- Clean rise (STABLE_CYCLES=4): `din` 0→1 captured at edge 10 and held → `dout`=1 and `rise`=1 at edge 15, `rise`=0 at edge 16, `count`=1.
- Glitch rejection (STABLE_CYCLES=4): `din` high for 3 cycles, then low → `dout`, `rise` and `fall` stay 0, `count` stays 0.
- Fall path: from HIGH, `din` low for 4 cycles → `fall` pulses once at the E+5 edge, `dout`=0, `count` unchanged.
- Saturation (CNT_W=2): 5 qualified high pulses separated by qualified lows → `count` reads 1, 2, 3, 3, 3.
- `clr` coincident with a commit to HIGH → `dout`=1, `rise`=1, `count`=0. Repeat with the macro undefined → `count`=0 throughout, `dout`/`rise` timing identical.
